// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - opcodes, ALU function and FSM state encodings for the ALU op sequencer
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_WB     = 2'b11
  } state_e;

  function automatic logic [15:0] sext5(input logic [4:0] value);
    return {{11{value[4]}}, value};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction, register-file and ALU signal bundle of the sequencer
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_sr1_addr;
  logic [2:0]  rf_sr2_addr;
  logic [15:0] rf_sr1_data;
  logic [15:0] rf_sr2_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b_reg;
  logic [15:0] alu_imm;
  logic        alu_imm_sel;
  logic [1:0]  alu_aluk;
  logic [15:0] alu_result;
  logic        rf_ld;
  logic [2:0]  rf_dr_addr;
  logic [15:0] rf_wdata;
  logic [2:0]  cc_nzp;
  logic        done;
  logic        illegal;

  modport master (
    input  instr_valid, instr, rf_sr1_data, rf_sr2_data, alu_result,
    output instr_ready, rf_sr1_addr, rf_sr2_addr, alu_a, alu_b_reg, alu_imm,
           alu_imm_sel, alu_aluk, rf_ld, rf_dr_addr, rf_wdata, cc_nzp, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_sr1_data, rf_sr2_data, alu_result,
    input  instr_ready, rf_sr1_addr, rf_sr2_addr, alu_a, alu_b_reg, alu_imm,
           alu_imm_sel, alu_aluk, rf_ld, rf_dr_addr, rf_wdata, cc_nzp, done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_nzp_calc.sv
// rtl/alu_op_sequencer_nzp_calc.sv - combinational {N,Z,P} classification of a 16-bit value
module nzp_calc (
  input  logic [15:0] value,
  output logic [2:0]  nzp
);
  always_comb begin
    nzp = 3'b001;
    if (value[15])
      nzp = 3'b100;
    else if (value == 16'h0000)
      nzp = 3'b010;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - LC-3 ADD/AND/NOT sequencer (IDLE/DECODE/EXEC/WB)
// Condition-code register present only when ALU_SEQ_CC_EN is defined.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  alu_op_sequencer_if.master  bus
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] result_q;
  logic [3:0]  opcode;
  logic        legal;
  logic        accept;

  assign opcode = ir_q[15:12];
  assign legal  = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
  assign accept = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      if (accept)
        ir_q <= bus.instr;
      if (state_q == ST_EXEC)
        result_q <= bus.alu_result;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = (state_q == ST_IDLE) && !rst;
    bus.rf_sr1_addr = ir_q[8:6];
    bus.rf_sr2_addr = ir_q[2:0];
    bus.alu_a       = bus.rf_sr1_data;
    bus.alu_b_reg   = bus.rf_sr2_data;
    bus.alu_imm     = sext5(ir_q[4:0]);
    bus.alu_imm_sel = 1'b0;
    bus.alu_aluk    = ALUK_PASS;
    bus.rf_ld       = (state_q == ST_WB);
    bus.rf_dr_addr  = ir_q[11:9];
    bus.rf_wdata    = result_q;
    bus.done        = (state_q == ST_WB);
    bus.illegal     = (state_q == ST_DECODE) && !legal;
    if (state_q == ST_EXEC) begin
      case (opcode)
        OP_ADD: begin
          bus.alu_aluk    = ALUK_ADD;
          bus.alu_imm_sel = ir_q[5];
        end
        OP_AND: begin
          bus.alu_aluk    = ALUK_AND;
          bus.alu_imm_sel = ir_q[5];
        end
        OP_NOT:  bus.alu_aluk = ALUK_NOT;
        default: bus.alu_aluk = ALUK_PASS;
      endcase
    end
  end

`ifdef ALU_SEQ_CC_EN
  logic [2:0] cc_q;
  logic [2:0] cc_next;

  nzp_calc u_nzp_calc (
    .value (bus.alu_result),
    .nzp   (cc_next)
  );

  // Loaded alongside the result register so the new flags are visible during WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cc_q <= 3'b010;
    else if (state_q == ST_EXEC)
      cc_q <= cc_next;
  end

  assign bus.cc_nzp = cc_q;
`else
  assign bus.cc_nzp = 3'b000;
`endif

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, 8 registers.
REQ-002 Clk  in  1  sole clock, rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  sequencer can accept an instruction.
REQ-006 instr  in  16  LC-3 instruction word.
REQ-007 rf_sr1_addr, rf_sr2_addr  out  3 each  register-file read addresses.
REQ-008 rf_sr1_data, rf_sr2_data  in  16 each  combinational read data.
REQ-009 alu_a, alu_b_reg, alu_imm  out  16 each  ALU A operand, SR2 operand, sign-extended immediate.
REQ-010 alu_imm_sel  out  1  1 = immediate operand; alu_aluk  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS.
REQ-011 alu_result  in  16  combinational ALU output.
REQ-012 rf_ld  out  1  write strobe; rf_dr_addr  out  3; rf_wdata  out  16.
REQ-013 cc_nzp  out  3  condition codes {N,Z,P}.
REQ-014 done  out  1  one-cycle pulse on writeback; illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-015 FSM states IDLE, DECODE, EXEC, WB; sole transitions: IDLE->DECODE on instr_valid&instr_ready; DECODE->EXEC (legal opcode) or DECODE->IDLE (illegal); EXEC->WB; WB->IDLE.
REQ-016 instr_ready SHALL be 1 only in IDLE with Reset low; instr captured into IR on the accepting edge.
REQ-017 Legal opcodes IR[15:12]: 0001 ADD, 0101 AND, 1001 NOT; all others illegal.
REQ-018 In DECODE and EXEC: rf_sr1_addr=IR[8:6]; rf_sr2_addr=IR[2:0]; alu_a=rf_sr1_data; alu_b_reg=rf_sr2_data; alu_imm = IR[4:0] sign-extended from bit 4 to 16 bits.
REQ-019 alu_imm_sel = IR[5] for ADD/AND, 0 for NOT and outside EXEC; alu_aluk per opcode in EXEC, 11 otherwise.
REQ-020 Result register loads alu_result at end of EXEC.
REQ-021 In WB: rf_ld=1, rf_dr_addr=IR[11:9], rf_wdata=result register, done=1; rf_ld=0 in all other states.
REQ-022 Latency: accept edge T -> DECODE cycle T+1, EXEC T+2, WB/done T+3; instr_ready high again T+4; throughput one instruction per 4 cycles.
REQ-023 Illegal: illegal=1 during DECODE cycle (T+1); no write, no CC change; instr_ready at T+2.
REQ-024 CC update at WB edge: N=result[15], Z=(result==0), P=otherwise; exactly one bit set.
REQ-025 instr_valid ignored outside IDLE; instr may change freely after capture.

Reset
REQ-026 Reset asserted (any state, incl. mid-operation): state IDLE, IR=0, result=0, cc_nzp=010, rf_ld=0, done=0, illegal=0, instr_ready=0; no partial write issued.
REQ-027 instr_ready rises the first cycle Reset is low.

Configuration
REQ-028 Macro ALU_SEQ_CC_EN: defined -> CC register and REQ-024 present; undefined -> no CC register, cc_nzp tied 000, all other behaviour identical.

Structure
REQ-029 Package alu_seq_pkg holds opcode constants, ALUK encoding enum, FSM state enum.
REQ-030 One sub-module natural: nzp_calc (combinational 16-bit -> NZP), instantiated only under ALU_SEQ_CC_EN.

Verification
REQ-031 ADD R1,R2,R3 (16'h1283), R2=5, R3=7 -> EXEC: sr1=2, sr2=3, imm_sel=0, aluk=00; WB at T+3: rf_dr_addr=1, rf_wdata=12, cc=001.
REQ-032 ADD R4,R4,#-1 (16'h193F), R4=0 -> alu_imm=16'hFFFF, imm_sel=1; rf_wdata=16'hFFFF, cc=100.
REQ-033 AND R0,R0,#0 (16'h5020), R0=16'h1234 -> aluk=01, rf_wdata=0, cc=010.
REQ-034 NOT R5,R6 (16'h9BBF), R6=16'h00FF -> aluk=10, rf_dr_addr=5, rf_wdata=16'hFF00, cc=100.
REQ-035 instr=16'h0000 -> illegal pulse at T+1, rf_ld never high, cc unchanged, instr_ready at T+2.
REQ-036 Reset asserted during EXEC of 16'h1283 -> rf_ld never high, cc=010, instr_ready 1 the cycle after release; with ALU_SEQ_CC_EN undefined, cc_nzp stays 000 throughout.
